// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: shares one write port between pipeline writeback and a
// queued auxiliary result source. Optional starvation guard enabled by STARVE_GUARD_EN.
module wb_port_arbiter #(
  parameter int Width        = 32,
  parameter int RegAddrWidth = 4,
  parameter int QDepth       = 2,
  parameter int StarveLimit  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pipe_wb_en_in,
  input  logic [RegAddrWidth-1:0]   pipe_wb_dest_in,
  input  logic [Width-1:0]          pipe_wb_value_in,
  input  logic                      aux_valid_in,
  input  logic [RegAddrWidth-1:0]   aux_dest_in,
  input  logic [Width-1:0]          aux_value_in,
  output logic                      aux_ready_out,
  output logic                      rf_we_out,
  output logic [RegAddrWidth-1:0]   rf_waddr_out,
  output logic [Width-1:0]          rf_wdata_out,
  output logic                      stall_out,
  output logic [$clog2(QDepth):0]   aux_count_out
);

  localparam int PtrW = $clog2(QDepth);
  localparam int CntW = PtrW + 1;

  logic [RegAddrWidth-1:0] dest_mem  [QDepth];
  logic [Width-1:0]        value_mem [QDepth];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            stall_q;
  logic            enq;
  logic            grant_aux;

  // Readiness looks at occupancy only, so a full queue refuses even while draining.
  assign aux_ready_out = rst && (count_q != CntW'(QDepth));
  assign enq           = aux_valid_in && aux_ready_out;
  assign grant_aux     = rst && (count_q != '0) && (!pipe_wb_en_in || stall_q);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (grant_aux) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({enq, grant_aux})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      dest_mem[wr_ptr_q]  <= aux_dest_in;
      value_mem[wr_ptr_q] <= aux_value_in;
    end
  end

`ifdef STARVE_GUARD_EN
  localparam int StW = $clog2(StarveLimit + 1);

  logic [StW-1:0] starve_q;
  logic [StW-1:0] starve_inc;

  assign starve_inc = starve_q + StW'(1);

  // A stall cycle always grants the head, so stall_q drops on the following edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else if ((count_q == '0) || grant_aux) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else if (starve_inc == StW'(StarveLimit)) begin
      starve_q <= '0;
      stall_q  <= 1'b1;
    end else begin
      starve_q <= starve_inc;
      stall_q  <= 1'b0;
    end
  end
`else
  assign stall_q = 1'b0;
`endif

  always_comb begin
    rf_we_out    = 1'b0;
    rf_waddr_out = '0;
    rf_wdata_out = '0;
    if (grant_aux) begin
      rf_we_out    = 1'b1;
      rf_waddr_out = dest_mem[rd_ptr_q];
      rf_wdata_out = value_mem[rd_ptr_q];
    end else if (rst && pipe_wb_en_in && !stall_q) begin
      rf_we_out    = 1'b1;
      rf_waddr_out = pipe_wb_dest_in;
      rf_wdata_out = pipe_wb_value_in;
    end
  end

  assign stall_out     = stall_q;
  assign aux_count_out = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter; expected RF writes are queued with their cycle.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pe;
  logic [3:0]  pd;
  logic [31:0] pv;
  logic        av;
  logic [3:0]  ad;
  logic [31:0] avv;
  logic        aux_ready;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall;
  logic [1:0]  count;

  wb_port_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .pipe_wb_en_in    (pe),
    .pipe_wb_dest_in  (pd),
    .pipe_wb_value_in (pv),
    .aux_valid_in     (av),
    .aux_dest_in      (ad),
    .aux_value_in     (avv),
    .aux_ready_out    (aux_ready),
    .rf_we_out        (rf_we),
    .rf_waddr_out     (rf_waddr),
    .rf_wdata_out     (rf_wdata),
    .stall_out        (stall),
    .aux_count_out    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every DUT write must match the next queued expectation, including its cycle.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write cyc=%0d got addr=%0d data=%h want no write", cyc, rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.addr !== rf_waddr || e.data !== rf_wdata) begin
          bad++;
          $display("FAIL rf_write cyc=%0d got addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                   cyc, rf_waddr, rf_wdata, e.cyc, e.addr, e.data);
        end else begin
          $display("write ok cyc=%0d addr=%0d data=%h", cyc, rf_waddr, rf_wdata);
        end
      end
    end
  end

  task automatic set_in(input logic p_en, input logic [3:0] p_d, input logic [31:0] p_v,
                        input logic a_v, input logic [3:0] a_d, input logic [31:0] a_val);
    pe = p_en; pd = p_d; pv = p_v; av = a_v; ad = a_d; avv = a_val;
  endtask

  // One cycle: queue the expected write, then check status at the falling edge.
  task automatic step(input string name, input logic ew, input logic [3:0] ea, input logic [31:0] ed,
                      input logic er, input logic [1:0] ec, input logic es);
    wr_t e;
    if (ew) begin
      e.cyc = cyc; e.addr = ea; e.data = ed;
      exp_q.push_back(e);
    end
    @(negedge clk);
    total++;
    if (aux_ready !== er || count !== ec || stall !== es) begin
      bad++;
      $display("FAIL %s got ready=%b count=%0d stall=%b want ready=%b count=%0d stall=%b",
               name, aux_ready, count, stall, er, ec, es);
    end else begin
      $display("step %s ready=%b count=%0d stall=%b", name, aux_ready, count, stall);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    set_in(1'b1, 4'd5, 32'h1234, 1'b1, 4'd3, 32'hDEAD);
    @(posedge clk);
    #1;
    step("reset", 1'b0, 4'd0, 32'h0, 1'b0, 2'd0, 1'b0);

    rst = 1'b1;
    set_in(1'b1, 4'd5, 32'h1234, 1'b0, 4'd0, 32'h0);
    step("pipe_only", 1'b1, 4'd5, 32'h1234, 1'b1, 2'd0, 1'b0);
    set_in(1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 32'hDEAD);
    step("aux_enq", 1'b0, 4'd0, 32'h0, 1'b1, 2'd0, 1'b0);
    set_in(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step("aux_write", 1'b1, 4'd3, 32'hDEAD, 1'b1, 2'd1, 1'b0);
    step("aux_drained", 1'b0, 4'd0, 32'h0, 1'b1, 2'd0, 1'b0);

    set_in(1'b1, 4'd1, 32'h11, 1'b1, 4'd7, 32'h77);
    step("full_1", 1'b1, 4'd1, 32'h11, 1'b1, 2'd0, 1'b0);
    set_in(1'b1, 4'd2, 32'h22, 1'b1, 4'd8, 32'h88);
    step("full_2", 1'b1, 4'd2, 32'h22, 1'b1, 2'd1, 1'b0);
    set_in(1'b1, 4'd3, 32'h33, 1'b1, 4'd9, 32'h99);
    step("full_held", 1'b1, 4'd3, 32'h33, 1'b0, 2'd2, 1'b0);
    set_in(1'b1, 4'd4, 32'h44, 1'b1, 4'd9, 32'h99);
    step("full_held2", 1'b1, 4'd4, 32'h44, 1'b0, 2'd2, 1'b0);
    set_in(1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 32'h99);
    step("full_drain", 1'b1, 4'd7, 32'h77, 1'b0, 2'd2, 1'b0);
    step("full_enq3", 1'b1, 4'd8, 32'h88, 1'b1, 2'd1, 1'b0);
    set_in(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step("full_last", 1'b1, 4'd9, 32'h99, 1'b1, 2'd1, 1'b0);
    step("full_empty", 1'b0, 4'd0, 32'h0, 1'b1, 2'd0, 1'b0);

    set_in(1'b1, 4'd10, 32'hA0, 1'b1, 4'd12, 32'hC0C0);
    step("starve_enq", 1'b1, 4'd10, 32'hA0, 1'b1, 2'd0, 1'b0);
    set_in(1'b1, 4'd11, 32'hA1, 1'b0, 4'd0, 32'h0);
    step("starve_1", 1'b1, 4'd11, 32'hA1, 1'b1, 2'd1, 1'b0);
    set_in(1'b1, 4'd13, 32'hA2, 1'b0, 4'd0, 32'h0);
    step("starve_2", 1'b1, 4'd13, 32'hA2, 1'b1, 2'd1, 1'b0);
    set_in(1'b1, 4'd14, 32'hA3, 1'b0, 4'd0, 32'h0);
    step("starve_3", 1'b1, 4'd14, 32'hA3, 1'b1, 2'd1, 1'b0);
    set_in(1'b1, 4'd15, 32'hA4, 1'b0, 4'd0, 32'h0);
    step("starve_4", 1'b1, 4'd15, 32'hA4, 1'b1, 2'd1, 1'b0);
    set_in(1'b1, 4'd1, 32'hA5, 1'b0, 4'd0, 32'h0);
`ifdef STARVE_GUARD_EN
    step("starve_stall", 1'b1, 4'd12, 32'hC0C0, 1'b1, 2'd1, 1'b1);
    step("starve_repres", 1'b1, 4'd1, 32'hA5, 1'b1, 2'd0, 1'b0);
    set_in(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step("starve_idle", 1'b0, 4'd0, 32'h0, 1'b1, 2'd0, 1'b0);
`else
    step("nostall_5", 1'b1, 4'd1, 32'hA5, 1'b1, 2'd1, 1'b0);
    set_in(1'b1, 4'd2, 32'hA6, 1'b0, 4'd0, 32'h0);
    step("nostall_6", 1'b1, 4'd2, 32'hA6, 1'b1, 2'd1, 1'b0);
    set_in(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step("nostall_drain", 1'b1, 4'd12, 32'hC0C0, 1'b1, 2'd1, 1'b0);
`endif

    set_in(1'b1, 4'd2, 32'hB0, 1'b1, 4'd4, 32'hE1);
    step("mid_fill1", 1'b1, 4'd2, 32'hB0, 1'b1, 2'd0, 1'b0);
    set_in(1'b1, 4'd3, 32'hB1, 1'b1, 4'd5, 32'hE2);
    step("mid_fill2", 1'b1, 4'd3, 32'hB1, 1'b1, 2'd1, 1'b0);
    rst = 1'b0;
    set_in(1'b1, 4'd6, 32'hB2, 1'b0, 4'd0, 32'h0);
    step("mid_rst", 1'b0, 4'd0, 32'h0, 1'b0, 2'd2, 1'b0);
    rst = 1'b1;
    set_in(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step("mid_cleared", 1'b0, 4'd0, 32'h0, 1'b1, 2'd0, 1'b0);
    step("mid_quiet", 1'b0, 4'd0, 32'h0, 1'b1, 2'd0, 1'b0);

    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_writes got %0d outstanding want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
